// File: rtl/interboard_tx_scheduler_pkg.sv
// ============================================================================
// interboard_tx_scheduler_pkg : shared message fields, types and FSM encoding
// Revision: 1.0
// ============================================================================
`default_nettype none

package interboard_tx_scheduler_pkg;

    localparam int c_type_w = 3;
    localparam int c_num_w  = 5;

    typedef enum logic [2:0] {
        MSG_NOP    = 3'd0,
        MSG_SYS    = 3'd1,
        MSG_DATA   = 3'd2,
        MSG_ACK    = 3'd3,
        MSG_NACK   = 3'd4,
        MSG_STATUS = 3'd5,
        MSG_CFG    = 3'd6,
        MSG_RESET  = 3'd7
    } msg_type_e;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_FIRE      = 3'd2,
        ST_WAIT_BUSY = 3'd3,
        ST_WAIT_DONE = 3'd4
    } tx_state_e;

    typedef struct packed {
        logic [c_type_w-1:0] msg_type;
        logic [c_num_w-1:0]  number;
    } msg_t;

endpackage

`default_nettype wire

// File: rtl/interboard_tx_scheduler_msg_fifo.sv
// ============================================================================
// msg_fifo : outgoing message queue of {type, number} entries, sync flush
// Revision: 1.0
// ============================================================================
`default_nettype none

module msg_fifo
    import interboard_tx_scheduler_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic flush,
    input  logic push,
    input  msg_t push_msg,
    input  logic pop,
    output msg_t head_msg,
    output logic empty,
    output logic full
);

    localparam int c_aw = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_cw = $clog2(DEPTH + 1);
    localparam logic [c_aw-1:0] c_last  = c_aw'(DEPTH - 1);
    localparam logic [c_cw-1:0] c_depth = c_cw'(DEPTH);

    msg_t            mem_q [DEPTH];
    msg_t            mem_d [DEPTH];
    logic [c_aw-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_aw-1:0] rd_ptr_q, rd_ptr_d;
    logic [c_cw-1:0] count_q, count_d;
    logic            do_push;
    logic            do_pop;

    function automatic logic [c_aw-1:0] ptr_inc(input logic [c_aw-1:0] p);
        return (p == c_last) ? '0 : p + 1'b1;
    endfunction

    assign empty    = (count_q == '0);
    assign full     = (count_q == c_depth);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign head_msg = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_msg;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Storage needs no reset; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/interboard_tx_scheduler.sv
// ============================================================================
// interboard_tx_scheduler : prioritised request arbiter, message queue and
// link-transmitter handshake FSM.   Revision: 1.0
// ============================================================================
`default_nettype none

module interboard_tx_scheduler
    import interboard_tx_scheduler_pkg::*;
#(
    parameter int NUM_REQ      = 3,
    parameter int FIFO_DEPTH   = 4,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         interboard_rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [c_type_w*NUM_REQ-1:0]  req_msg_type,
    input  logic [c_num_w*NUM_REQ-1:0]   req_number,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic                         inter_ready,
    output logic                         ctrl_en,
    output logic [c_type_w-1:0]          ctrl_msg_type,
    output logic [c_num_w-1:0]           ctrl_number,
    output logic                         transmit,
    output logic                         busy,
    output logic                         timeout_err
);

    localparam int c_pw = $clog2(NUM_REQ);
    localparam int c_tw = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
    localparam logic [c_pw-1:0] c_rr_first = c_pw'(1);
    localparam logic [c_pw-1:0] c_last_req = c_pw'(NUM_REQ - 1);
    localparam logic [c_tw-1:0] c_tmo_last = c_tw'(BUSY_TIMEOUT - 1);

    msg_t            req_msg [NUM_REQ];
    logic [NUM_REQ-1:0] grant;
    logic [c_pw-1:0] grant_idx;
    logic            found;
    logic            accept_ok;
    logic            push;
    msg_t            push_msg;
    logic            pop;
    msg_t            head_msg;
    logic            fifo_empty;
    logic            fifo_full;

    logic [c_pw-1:0] rr_ptr_q, rr_ptr_d;
    tx_state_e       state_q, state_d;
    logic [c_tw-1:0] timer_q, timer_d;
    logic            ctrl_en_q, ctrl_en_d;
    msg_t            ctrl_msg_q, ctrl_msg_d;
    logic            transmit_q, transmit_d;
    logic            timeout_err_q, timeout_err_d;
    logic            run_q;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign req_msg[gi] = {req_msg_type[c_type_w*gi +: c_type_w],
                              req_number[c_num_w*gi +: c_num_w]};
    end

    function automatic logic [c_pw-1:0] rr_index(input logic [c_pw-1:0] ptr, input int k);
        int idx;
        idx = int'(ptr) + k;
        if (idx >= NUM_REQ) begin
            idx = idx - (NUM_REQ - 1);
        end
        return idx[c_pw-1:0];
    endfunction

    // run_q holds off grants for the first cycle after reset release so the
    // asynchronous reset never feeds the datapath directly.
    assign accept_ok = run_q && !fifo_full && !interboard_rst;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        rr_ptr_d  = rr_ptr_q;
        if (accept_ok) begin
            if (req_valid[0]) begin
                grant[0] = 1'b1;
                found    = 1'b1;
            end else begin
                for (int k = 0; k < NUM_REQ - 1; k++) begin
                    if (!found && req_valid[rr_index(rr_ptr_q, k)]) begin
                        grant_idx        = rr_index(rr_ptr_q, k);
                        grant[grant_idx] = 1'b1;
                        found            = 1'b1;
                    end
                end
            end
        end
        if (found && grant_idx != '0) begin
            rr_ptr_d = (grant_idx == c_last_req) ? c_rr_first : grant_idx + 1'b1;
        end
        if (interboard_rst) begin
            rr_ptr_d = c_rr_first;
        end
    end

    assign req_ready = grant;
    assign push      = found;
    assign push_msg  = req_msg[grant_idx];

    msg_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (interboard_rst),
        .push     (push),
        .push_msg (push_msg),
        .pop      (pop),
        .head_msg (head_msg),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );

    always_comb begin
        state_d       = state_q;
        timer_d       = '0;
        ctrl_en_d     = ctrl_en_q;
        ctrl_msg_d    = ctrl_msg_q;
        transmit_d    = 1'b0;
        timeout_err_d = timeout_err_q;
        pop           = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // A same-cycle push into an empty queue is forwarded so LOAD
                // starts right after the accept.
                if ((!fifo_empty || push) && inter_ready) begin
                    state_d    = ST_LOAD;
                    ctrl_en_d  = 1'b1;
                    ctrl_msg_d = fifo_empty ? push_msg : head_msg;
                end
            end
            ST_LOAD: begin
                pop        = 1'b1;
                transmit_d = 1'b1;
                state_d    = ST_FIRE;
            end
            ST_FIRE: begin
                state_d = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (!inter_ready) begin
                    state_d = ST_WAIT_DONE;
                end else if (timer_q == c_tmo_last) begin
                    state_d       = ST_IDLE;
                    timeout_err_d = 1'b1;
                    ctrl_en_d     = 1'b0;
                    ctrl_msg_d    = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                if (inter_ready) begin
                    state_d    = ST_IDLE;
                    ctrl_en_d  = 1'b0;
                    ctrl_msg_d = '0;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                ctrl_en_d  = 1'b0;
                ctrl_msg_d = '0;
            end
        endcase
        if (interboard_rst) begin
            state_d       = ST_IDLE;
            timer_d       = '0;
            ctrl_en_d     = 1'b0;
            ctrl_msg_d    = '0;
            transmit_d    = 1'b0;
            timeout_err_d = 1'b0;
            pop           = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q      <= c_rr_first;
            state_q       <= ST_IDLE;
            timer_q       <= '0;
            ctrl_en_q     <= 1'b0;
            ctrl_msg_q    <= '0;
            transmit_q    <= 1'b0;
            timeout_err_q <= 1'b0;
            run_q         <= 1'b0;
        end else begin
            rr_ptr_q      <= rr_ptr_d;
            state_q       <= state_d;
            timer_q       <= timer_d;
            ctrl_en_q     <= ctrl_en_d;
            ctrl_msg_q    <= ctrl_msg_d;
            transmit_q    <= transmit_d;
            timeout_err_q <= timeout_err_d;
            run_q         <= 1'b1;
        end
    end

    assign ctrl_en       = ctrl_en_q;
    assign ctrl_msg_type = ctrl_msg_q.msg_type;
    assign ctrl_number   = ctrl_msg_q.number;
    assign transmit      = transmit_q;
    assign busy          = !fifo_empty || (state_q != ST_IDLE);
    assign timeout_err   = timeout_err_q;

endmodule

`default_nettype wire

// File: tb/tb_interboard_tx_scheduler.sv
// ============================================================================
// tb_interboard_tx_scheduler : directed vector table plus corner sequences
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_interboard_tx_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        interboard_rst;
    logic [2:0]  req_valid;
    logic [8:0]  req_msg_type;
    logic [14:0] req_number;
    logic [2:0]  req_ready;
    logic        inter_ready;
    logic        ctrl_en;
    logic [2:0]  ctrl_msg_type;
    logic [4:0]  ctrl_number;
    logic        transmit;
    logic        busy;
    logic        timeout_err;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       rst;
        logic [2:0] valid;
        logic [2:0] exp_ready;
        logic       exp_busy;
    } vec_t;

    vec_t tbl [13];

    always #5 clk = ~clk;

    interboard_tx_scheduler #(
        .NUM_REQ      (3),
        .FIFO_DEPTH   (4),
        .BUSY_TIMEOUT (16)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .interboard_rst (interboard_rst),
        .req_valid      (req_valid),
        .req_msg_type   (req_msg_type),
        .req_number     (req_number),
        .req_ready      (req_ready),
        .inter_ready    (inter_ready),
        .ctrl_en        (ctrl_en),
        .ctrl_msg_type  (ctrl_msg_type),
        .ctrl_number    (ctrl_number),
        .transmit       (transmit),
        .busy           (busy),
        .timeout_err    (timeout_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({req_ready, ctrl_en, ctrl_msg_type, ctrl_number, transmit, busy, timeout_err});
    endfunction

    task automatic do_reset();
        req_valid      = 3'b000;
        interboard_rst = 1'b0;
        inter_ready    = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("reset_outputs_zero", all_outs(), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic apply_vec(input int i);
        if (tbl[i].rst) do_reset();
        req_valid = tbl[i].valid;
        settle();
        chk($sformatf("vec%0d_ready", i), 32'(req_ready), 32'(tbl[i].exp_ready));
        chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(tbl[i].exp_busy));
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int txc;
        rst_n          = 1'b0;
        interboard_rst = 1'b0;
        inter_ready    = 1'b0;
        req_valid      = 3'b000;
        req_msg_type   = {3'd6, 3'd2, 3'd1};
        req_number     = {5'd30, 5'd17, 5'd5};

        // Link held busy: fill order 0,1,2,1 then full; later reset-separated set.
        tbl[0]  = '{1'b1, 3'b000, 3'b000, 1'b0};
        tbl[1]  = '{1'b0, 3'b111, 3'b001, 1'b0};
        tbl[2]  = '{1'b0, 3'b110, 3'b010, 1'b1};
        tbl[3]  = '{1'b0, 3'b110, 3'b100, 1'b1};
        tbl[4]  = '{1'b0, 3'b110, 3'b010, 1'b1};
        tbl[5]  = '{1'b0, 3'b111, 3'b000, 1'b1};
        tbl[6]  = '{1'b0, 3'b011, 3'b000, 1'b1};
        tbl[7]  = '{1'b1, 3'b100, 3'b100, 1'b0};
        tbl[8]  = '{1'b0, 3'b010, 3'b010, 1'b1};
        tbl[9]  = '{1'b0, 3'b110, 3'b100, 1'b1};
        tbl[10] = '{1'b0, 3'b000, 3'b000, 1'b1};
        tbl[11] = '{1'b0, 3'b011, 3'b001, 1'b1};
        tbl[12] = '{1'b0, 3'b010, 3'b000, 1'b1};

        for (int i = 0; i < 7; i++) apply_vec(i);

        // Full queue: slot frees only after the LOAD pop, then requester 2 wins.
        req_valid   = 3'b110;
        inter_ready = 1'b1;
        settle();
        chk("full_idle_ready", 32'(req_ready), 32'd0);
        tick();
        settle();
        chk("full_load_ready", 32'(req_ready), 32'd0);
        chk("full_load_en", 32'(ctrl_en), 32'd1);
        chk("full_load_msg", 32'({ctrl_msg_type, ctrl_number}), 32'({3'd1, 5'd5}));
        tick();
        settle();
        chk("full_freed_grant", 32'(req_ready), 32'b100);
        chk("full_fire_tx", 32'(transmit), 32'd1);
        tick();
        settle();
        chk("full_again_ready", 32'(req_ready), 32'd0);
        req_valid = 3'b000;

        for (int i = 7; i < 13; i++) apply_vec(i);

        // Single push latency.
        do_reset();
        inter_ready = 1'b1;
        req_valid   = 3'b010;
        settle();
        chk("single_ready", 32'(req_ready), 32'b010);
        chk("single_en_before", 32'(ctrl_en), 32'd0);
        tick();
        req_valid = 3'b000;
        settle();
        chk("single_load_en", 32'(ctrl_en), 32'd1);
        chk("single_load_msg", 32'({ctrl_msg_type, ctrl_number}), 32'({3'd2, 5'd17}));
        chk("single_load_notx", 32'(transmit), 32'd0);
        tick();
        settle();
        chk("single_fire_tx", 32'(transmit), 32'd1);
        tick();
        settle();
        chk("single_tx_one_cycle", 32'(transmit), 32'd0);
        inter_ready = 1'b0;
        tick();
        settle();
        chk("single_hold_msg", 32'({ctrl_en, ctrl_msg_type, ctrl_number}), 32'({1'b1, 3'd2, 5'd17}));
        inter_ready = 1'b1;
        tick();
        settle();
        chk("single_idle_clear", 32'({ctrl_en, ctrl_msg_type, ctrl_number, busy, timeout_err}), 32'd0);

        // Timeout: inter_ready never falls.
        do_reset();
        inter_ready = 1'b1;
        req_valid   = 3'b011;
        settle();
        chk("tmo_grant0", 32'(req_ready), 32'b001);
        tick();
        req_valid = 3'b010;
        settle();
        chk("tmo_grant1", 32'(req_ready), 32'b010);
        tick();
        req_valid = 3'b000;
        settle();
        chk("tmo_fire_tx", 32'(transmit), 32'd1);
        tick();
        settle();
        chk("tmo_err_before", 32'(timeout_err), 32'd0);
        n = 0;
        while (ctrl_en === 1'b1 && n < 40) begin
            n++;
            tick();
            settle();
        end
        chk("tmo_wait_cycles", 32'(n), 32'd16);
        chk("tmo_err_set", 32'(timeout_err), 32'd1);
        tick();
        settle();
        chk("tmo_next_load", 32'({ctrl_en, ctrl_msg_type, ctrl_number}), 32'({1'b1, 3'd2, 5'd17}));
        tick();
        settle();
        chk("tmo_next_tx", 32'(transmit), 32'd1);
        chk("tmo_err_sticky", 32'(timeout_err), 32'd1);

        // Flush during WAIT_DONE with queued messages.
        do_reset();
        req_valid = 3'b110;
        tick();
        tick();
        tick();
        req_valid = 3'b000;
        settle();
        chk("flush_busy_queued", 32'(busy), 32'd1);
        inter_ready = 1'b1;
        tick();
        tick();
        settle();
        chk("flush_pre_tx", 32'(transmit), 32'd1);
        tick();
        inter_ready = 1'b0;
        tick();
        settle();
        chk("flush_pre_en", 32'(ctrl_en), 32'd1);
        interboard_rst = 1'b1;
        req_valid      = 3'b111;
        settle();
        chk("flush_blocks_ready", 32'(req_ready), 32'd0);
        tick();
        interboard_rst = 1'b0;
        req_valid      = 3'b000;
        settle();
        chk("flush_busy_clear", 32'(busy), 32'd0);
        chk("flush_en_clear", 32'(ctrl_en), 32'd0);
        inter_ready = 1'b1;
        txc = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            settle();
            if (transmit === 1'b1) txc++;
        end
        chk("flush_no_transmit", 32'(txc), 32'd0);

        // Asynchronous reset in FIRE.
        do_reset();
        inter_ready = 1'b1;
        req_valid   = 3'b010;
        settle();
        tick();
        req_valid = 3'b000;
        tick();
        settle();
        chk("async_pre_fire", 32'({transmit, ctrl_en}), 32'b11);
        rst_n     = 1'b0;
        req_valid = 3'b111;
        #1;
        chk("async_drop", all_outs(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
